// File: rtl/ariane_profiler_dump_ctrl_pkg.sv
// ariane_prof_pkg: shared command/state encodings and header magic for the profiler dump controller
package ariane_prof_pkg;
  typedef enum logic [1:0] {CMD_START, CMD_STOP, CMD_CLEAR, CMD_DUMP} prof_cmd_e;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} dump_state_e;
  localparam logic [7:0] PROF_HDR_MAGIC = 8'hA5;
endpackage

// File: rtl/ariane_profiler_dump_ctrl_tick_gen.sv
// ariane_prof_tick_gen: free-running period timer that emits a one-cycle auto-dump tick
module ariane_prof_tick_gen (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] period_i,
  input  logic        en_i,
  input  logic        clear_i,
  output logic        tick_o
);
  logic [31:0] timer;
  logic run;
  assign run = en_i && period_i != '0;
  // >= rather than == so a period shrunk below the current count still fires
  assign tick_o = run && timer >= period_i - 32'd1;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) timer <= '0;
    else if (clear_i || tick_o) timer <= '0;
    else if (run) timer <= timer + 32'd1;
endmodule

// File: rtl/ariane_profiler_dump_ctrl.sv
// ariane_profiler_dump_ctrl: run control, atomic snapshot and header+data streaming
// of the issue-stall profiler counter bank.
module ariane_profiler_dump_ctrl import ariane_prof_pkg::*; #(
  parameter int width_p        = 64,
  parameter int num_counters_p = 35,
  parameter int out_width_p    = 32
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              cmd_v_i,
  input  logic [1:0]                        cmd_i,
  output logic                              cmd_ready_o,
  input  logic [31:0]                       period_i,
  input  logic [num_counters_p*width_p-1:0] counters_i,
  output logic                              prof_en_o,
  output logic                              prof_clear_o,
  output logic [out_width_p-1:0]            data_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic                              busy_o,
  output logic                              overrun_o
);
  localparam int wpc = width_p / out_width_p;
  localparam int nw  = num_counters_p * wpc;
  localparam int ww  = wpc > 1 ? $clog2(wpc) : 1;
  localparam int pw  = nw > 1 ? $clog2(nw) : 1;
  dump_state_e state;
  prof_cmd_e cmd;
  logic [out_width_p-1:0] shadow [nw];
  logic [7:0] idx;
  logic [ww-1:0] wrd;
  logic [15:0] seq;
  logic [pw-1:0] ptr;
  logic pending, tick, tick_v, acc, clr_acc, dump_acc, req, hs, wrd_last, last;
  assign cmd = prof_cmd_e'(cmd_i);
  assign cmd_ready_o = state == ST_IDLE || cmd <= CMD_STOP;
  assign acc = cmd_v_i && cmd_ready_o;
  assign clr_acc = acc && cmd == CMD_CLEAR;
  assign dump_acc = acc && cmd == CMD_DUMP;
  ariane_prof_tick_gen u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .period_i(period_i),
    .en_i    (prof_en_o),
    .clear_i (clr_acc),
    .tick_o  (tick)
  );
  // a CLEAR swallows any tick or leftover pending request of its own cycle
  assign tick_v = tick && !clr_acc;
  assign req = dump_acc || ((tick || pending) && !clr_acc);
  assign v_o = state != ST_IDLE;
  assign busy_o = v_o;
  assign hs = v_o && ready_i;
  assign wrd_last = wrd == ww'(wpc - 1);
  assign last = wrd_last && idx == 8'(num_counters_p - 1);
  assign ptr = pw'(32'(idx) * 32'(wpc) + 32'(wrd));
  // the stream word is a pure function of state/seq/shadow/idx/wrd registers
  assign data_o = state == ST_HDR ? {PROF_HDR_MAGIC, 8'(num_counters_p), seq}
                : state == ST_DATA ? shadow[ptr] : '0;
  always_ff @(posedge clk_i)
    if (state == ST_IDLE && req)
      for (int i = 0; i < nw; i++) shadow[i] <= counters_i[i*out_width_p +: out_width_p];
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      idx          <= '0;
      wrd          <= '0;
      seq          <= '0;
      pending      <= 1'b0;
      overrun_o    <= 1'b0;
      prof_en_o    <= 1'b0;
      prof_clear_o <= 1'b0;
    end else begin
      prof_clear_o <= clr_acc;
      if (acc && cmd == CMD_START) prof_en_o <= 1'b1;
      else if (acc && cmd == CMD_STOP) prof_en_o <= 1'b0;
      if (clr_acc) begin
        pending   <= 1'b0;
        overrun_o <= 1'b0;
      end else if (state == ST_IDLE) pending <= 1'b0;
      else if (tick_v) begin
        if (pending) overrun_o <= 1'b1;
        else pending <= 1'b1;
      end
      if (state == ST_IDLE) begin
        if (req) state <= ST_HDR;
      end else if (hs) begin
        if (state == ST_HDR) begin
          state <= ST_DATA;
          idx   <= '0;
          wrd   <= '0;
        end else if (last) begin
          state <= ST_IDLE;
          seq   <= seq + 16'd1;
        end else if (wrd_last) begin
          wrd <= '0;
          idx <= idx + 8'd1;
        end else wrd <= wrd + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ariane_profiler_dump_ctrl.sv
// tb_ariane_profiler_dump_ctrl: directed tables and sequences plus random traffic against a
// queue-based model of the dump stream.
module tb_ariane_profiler_dump_ctrl;
  import ariane_prof_pkg::*;
  localparam int W = 64, NC = 35, WPC = 2, DL = 1 + NC * WPC;
  logic clk = 0, reset_i = 1, cmd_v_i = 0, ready_i = 0;
  logic [1:0] cmd_i = 0;
  logic [31:0] period_i = 0;
  logic [NC*W-1:0] counters_i;
  logic cmd_ready_o, prof_en_o, prof_clear_o, v_o, busy_o, overrun_o;
  logic [31:0] data_o;
  always #5 clk = ~clk;
  ariane_profiler_dump_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o),
    .period_i(period_i), .counters_i(counters_i), .prof_en_o(prof_en_o), .prof_clear_o(prof_clear_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .busy_o(busy_o), .overrun_o(overrun_o)
  );
  int total = 0, bad = 0, cyc = 0, mode = 0, wcount = 0;
  bit rnd_ready = 0;
  logic [31:0] rx[$], hdr_val[$];
  int hdr_cyc[$];
  bit stall_prev;
  logic [31:0] prev_data;
  bit m_en, m_clr, m_ovr, m_pend, m_busy, m_rdy, b, acc, clr, dmp, tick, start;
  longint m_timer;
  logic [15:0] m_seq;
  logic [31:0] exp_q[$];
  typedef struct {logic [1:0] cmd; bit busy; bit rdy; bit en; bit clr; bit ovr;} vec_t;
  vec_t tbl[9];
  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  task automatic set_cnt();
    for (int k = 0; k < NC; k++)
      counters_i[k*W +: W] = mode == 2 ? {$urandom, $urandom}
                           : {32'(k), 32'(k + 1)} + (mode == 1 ? 64'(cyc) : 64'd0);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    set_cnt();
    if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
  endtask
  task automatic wait_idle(int lim);
    int n = 0;
    while (busy_o && n < lim) begin
      step();
      n++;
    end
    chk("idle_wait", 64'(busy_o), 0);
  endtask
  task automatic wait_hdr(int n, int lim);
    int k = 0;
    while (hdr_val.size() < n && k < lim) begin
      step();
      k++;
    end
    chk("hdr_wait", 64'(hdr_val.size() >= n), 1);
  endtask
  task automatic issue(logic [1:0] c);
    cmd_v_i = 1;
    cmd_i = c;
    step();
    cmd_v_i = 0;
  endtask
  task automatic do_reset();
    reset_i = 1;
    step();
    step();
    reset_i = 0;
    rx.delete();
    hdr_val.delete();
    hdr_cyc.delete();
  endtask
  initial forever @(posedge clk) cyc++;
  // model of the stream: a dump is the queue of words still owed to the host
  initial forever begin
    @(negedge clk);
    if (reset_i) begin
      {m_en, m_clr, m_ovr, m_pend, m_busy, stall_prev} = '0;
      m_timer = 0;
      m_seq = 0;
      wcount = 0;
      exp_q.delete();
    end else begin
      m_rdy = !m_busy || cmd_i <= 2'd1;
      chk("ctl", 64'({cmd_ready_o, prof_en_o, prof_clear_o, overrun_o, v_o, busy_o}),
          64'({m_rdy, m_en, m_clr, m_ovr, m_busy, m_busy}));
      if (m_busy) chk("data", 64'(data_o), 64'(exp_q[0]));
      if (stall_prev) chk("stall", 64'(data_o), 64'(prev_data));
      stall_prev = v_o && !ready_i;
      prev_data = data_o;
      if (v_o && ready_i) begin
        rx.push_back(data_o);
        if (wcount % DL == 0) begin
          hdr_val.push_back(data_o);
          hdr_cyc.push_back(cyc);
        end
        wcount++;
      end
      b = m_busy;
      acc = cmd_v_i && m_rdy;
      clr = acc && cmd_i == 2'd2;
      dmp = acc && cmd_i == 2'd3;
      tick = m_en && period_i != 0 && m_timer >= longint'(period_i) - 1;
      start = !b && (dmp || ((tick || m_pend) && !clr));
      if (b && tick) begin
        if (m_pend) m_ovr = 1;
        else m_pend = 1;
      end
      if (clr) {m_pend, m_ovr} = '0;
      if (b && ready_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 0;
          m_seq++;
        end
      end
      if (start) begin
        exp_q.push_back({8'hA5, 8'(NC), m_seq});
        for (int k = 0; k < NC * WPC; k++) exp_q.push_back(counters_i[k*32 +: 32]);
        m_busy = 1;
        m_pend = 0;
      end
      m_timer = (clr || tick) ? 0 : (m_en && period_i != 0) ? m_timer + 1 : m_timer;
      if (acc && cmd_i == 2'd0) m_en = 1;
      else if (acc && cmd_i == 2'd1) m_en = 0;
      m_clr = clr;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int mm, c0, n0;
    logic [NC*W-1:0] snap;
    logic [31:0] ref_w;
    logic [31:0] plist[4];
    plist = '{32'd0, 32'd37, 32'd90, 32'd150};
    tbl[0] = '{CMD_START, 0, 1, 1, 0, 1};
    tbl[1] = '{CMD_CLEAR, 0, 1, 1, 1, 0};
    tbl[2] = '{CMD_DUMP,  0, 1, 1, 0, 0};
    tbl[3] = '{CMD_CLEAR, 1, 0, 1, 0, 0};
    tbl[4] = '{CMD_DUMP,  1, 0, 1, 0, 0};
    tbl[5] = '{CMD_STOP,  1, 1, 0, 0, 0};
    tbl[6] = '{CMD_START, 1, 1, 1, 0, 0};
    tbl[7] = '{CMD_STOP,  0, 1, 0, 0, 0};
    tbl[8] = '{CMD_START, 0, 1, 1, 0, 0};
    set_cnt();
    // basic dump with static pattern and ready held high
    do_reset();
    chk("rst_out", 64'({data_o, v_o, busy_o, prof_en_o, prof_clear_o, overrun_o, cmd_ready_o}), 64'd1);
    ready_i = 1;
    issue(CMD_START);
    issue(CMD_DUMP);
    wait_idle(200);
    chk("t1_len", 64'(rx.size()), DL);
    chk("t1_hdr", 64'(rx[0]), 64'h0A5230000);
    chk("t1_w1", 64'(rx[1]), 1);
    chk("t1_w2", 64'(rx[2]), 0);
    chk("t1_w69", 64'(rx[69]), 35);
    chk("t1_w70", 64'(rx[70]), 34);
    issue(CMD_DUMP);
    wait_idle(200);
    chk("t1_seq1", 64'(rx[DL]), 64'h0A5230001);
    // same dump under random backpressure
    rx.delete();
    rnd_ready = 1;
    issue(CMD_DUMP);
    wait_idle(2000);
    rnd_ready = 0;
    ready_i = 1;
    chk("t2_len", 64'(rx.size()), DL);
    chk("t2_hdr", 64'(rx[0]), 64'h0A5230002);
    mm = 0;
    for (int j = 0; j < NC * WPC; j++) begin
      ref_w = (j % 2 == 0) ? 32'(j / 2 + 1) : 32'(j / 2);
      if (rx[j+1] !== ref_w) mm++;
    end
    chk("t2_words", 64'(mm), 0);
    // periodic dumps, then a long stall that loses a tick
    do_reset();
    ready_i = 1;
    period_i = 100;
    issue(CMD_START);
    wait_hdr(3, 500);
    chk("t3_gap1", 64'(hdr_cyc[1] - hdr_cyc[0]), 100);
    chk("t3_gap2", 64'(hdr_cyc[2] - hdr_cyc[1]), 100);
    chk("t3_seq", {16'(hdr_val[0]), 16'(hdr_val[1]), 16'(hdr_val[2])}, 48'h0000_0001_0002);
    ready_i = 0;
    repeat (250) step();
    chk("t3_overrun", 64'(overrun_o), 1);
    n0 = hdr_val.size();
    period_i = 0;
    ready_i = 1;
    repeat (400) step();
    chk("t3_extra", 64'(hdr_val.size() - n0), 1);
    // command acceptance table, idle and mid-dump
    rx.delete();
    ready_i = 0;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].busy && !busy_o) issue(CMD_DUMP);
      if (!tbl[i].busy && busy_o) begin
        ready_i = 1;
        wait_idle(200);
        ready_i = 0;
      end
      cmd_v_i = 1;
      cmd_i = tbl[i].cmd;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i), 64'(cmd_ready_o), 64'(tbl[i].rdy));
      step();
      cmd_v_i = 0;
      chk($sformatf("tbl%0d_en", i), 64'(prof_en_o), 64'(tbl[i].en));
      chk($sformatf("tbl%0d_clr", i), 64'(prof_clear_o), 64'(tbl[i].clr));
      chk($sformatf("tbl%0d_ovr", i), 64'(overrun_o), 64'(tbl[i].ovr));
    end
    chk("stop_no_abort", 64'(rx.size()), DL);
    step();
    chk("clr_pulse_end", 64'(prof_clear_o), 0);
    // CLEAR restarts the timer; a same-cycle tick is discarded
    ready_i = 1;
    period_i = 100;
    cmd_v_i = 1;
    cmd_i = CMD_CLEAR;
    @(negedge clk);
    c0 = cyc;
    step();
    cmd_v_i = 0;
    n0 = hdr_val.size();
    wait_hdr(n0 + 1, 200);
    chk("clr_restart", 64'(hdr_cyc[hdr_cyc.size()-1] - c0), 101);
    period_i = 0;
    wait_idle(200);
    // snapshot of counters that move every cycle
    rx.delete();
    mode = 1;
    step();
    cmd_v_i = 1;
    cmd_i = CMD_DUMP;
    @(negedge clk);
    snap = counters_i;
    step();
    cmd_v_i = 0;
    wait_idle(200);
    mode = 0;
    chk("t5_len", 64'(rx.size()), DL);
    mm = 0;
    for (int j = 0; j < NC * WPC; j++) if (rx[j+1] !== snap[j*32 +: 32]) mm++;
    chk("t5_snap", 64'(mm), 0);
    // asynchronous reset in the middle of the data phase
    issue(CMD_DUMP);
    repeat (20) step();
    @(posedge clk);
    #3 reset_i = 1;
    #1;
    chk("async_v", 64'(v_o), 0);
    chk("async_busy", 64'(busy_o), 0);
    step();
    reset_i = 0;
    rx.delete();
    hdr_val.delete();
    hdr_cyc.delete();
    issue(CMD_DUMP);
    wait_idle(200);
    chk("t6_hdr", 64'(rx[0]), 64'h0A5230000);
    // random traffic against the model
    do_reset();
    mode = 2;
    rnd_ready = 1;
    issue(CMD_START);
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) period_i = plist[$urandom_range(0, 3)];
      cmd_v_i = $urandom_range(0, 15) == 0;
      cmd_i = 2'($urandom_range(0, 3));
      step();
    end
    cmd_v_i = 0;
    period_i = 0;
    rnd_ready = 0;
    ready_i = 1;
    wait_idle(400);
    chk("rnd_dumps", 64'(hdr_val.size() > 2), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
